// File: rtl/pxs_pkg.sv
// Shared definitions for the pixel-stream stages: stream field positions,
// widths, colour constants, centre-line modes and the flash FSM state type.
package pxs_pkg;

    localparam int VGA_W   = 23;
    localparam int RGB_W   = 26;
    localparam int COORD_W = 10;

    localparam int ACTIVE_BIT = 0;
    localparam int VS_BIT     = 1;
    localparam int HS_BIT     = 2;
    localparam int YC_LSB     = 3;
    localparam int YC_MSB     = 12;
    localparam int XC_LSB     = 13;
    localparam int XC_MSB     = 22;
    localparam int R_BIT      = 23;
    localparam int G_BIT      = 24;
    localparam int B_BIT      = 25;
    localparam int RGB_LSB    = 23;
    localparam int RGB_MSB    = 25;
    localparam int VGA_LSB    = 0;
    localparam int VGA_MSB    = 22;

    // Colours are {B,G,R}, matching the order of RGBStr bits 25..23.
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        MODE_DASHED   = 2'b00,
        MODE_SOLID    = 2'b01,
        MODE_NOCENTRE = 2'b10,
        MODE_OFF      = 2'b11
    } mode_e;

    typedef enum logic {
        FLASH_IDLE = 1'b0,
        FLASH_ON   = 1'b1
    } flash_state_e;

endpackage

// File: rtl/pxs_frame_flash.sv
// Frame tick from the VS edge plus the goal-flash FSM that decides when the
// court colours are inverted.
module pxs_frame_flash
    import pxs_pkg::*;
#(
    parameter int   FLASH_FRAMES = 32,
    parameter int   FLASH_PERIOD = 4,
    parameter logic VS_ACTIVE    = 1'b0
) (
    input  logic         px_clk,
    input  logic         reset_n,
    input  logic         vs_i,
    input  logic         goal_i,
    output logic         tick_o,
    output logic         inv_o,
    output logic         flashing_o,
    output flash_state_e state_o
);

    localparam int                CNT_W    = $clog2(FLASH_FRAMES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

    logic              vs_q, vs_d;
    flash_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              odd_half;

    always_comb begin
        vs_d    = vs_i;
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_o  = (vs_i == VS_ACTIVE) && (vs_q != VS_ACTIVE);

        case (state_q)
            FLASH_IDLE: begin
                if (goal_i) begin
                    state_d = FLASH_ON;
                    cnt_d   = '0;
                end
            end
            FLASH_ON: begin
                // A goal restarts the flash even when it lands on a frame tick.
                if (goal_i) begin
                    cnt_d = '0;
                end else if (tick_o) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = FLASH_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = FLASH_IDLE;
                cnt_d   = '0;
            end
        endcase

        odd_half   = 1'((32'(cnt_q) / 32'(FLASH_PERIOD)) & 32'd1);
        inv_o      = (state_q == FLASH_ON) && !odd_half;
        flashing_o = (state_q == FLASH_ON);
        state_o    = state_q;
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q    <= ~VS_ACTIVE;
            state_q <= FLASH_IDLE;
            cnt_q   <= '0;
        end else begin
            vs_q    <= vs_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pxs_court_gen.sv
// Court renderer: draws top, bottom and centre lines onto the VGA stream,
// with a frame-synchronous mode shadow, blanking mask and goal flash.
module pxs_court_gen
    import pxs_pkg::*;
#(
    parameter int         WIDTH_SCREEN  = 640,
    parameter int         HEIGHT_SCREEN = 480,
    parameter int         WIDTH_LINE    = 6,
    parameter int         DASH_LEN      = 8,
    parameter logic [2:0] COURT_COLOR   = 3'b111,
    parameter logic [2:0] BG_COLOR      = 3'b000,
    parameter int         FLASH_FRAMES  = 32,
    parameter int         FLASH_PERIOD  = 4,
    parameter logic       VS_ACTIVE     = 1'b0
) (
    input  logic             px_clk,
    input  logic             reset_n,
    input  logic [VGA_W-1:0] VGAStr_i,
    input  logic [1:0]       mode_i,
    input  logic             goal_i,
    output logic [RGB_W-1:0] RGBStr_o,
    output logic             flashing_o
);

    localparam logic [COORD_W-1:0] TOP_END   = COORD_W'(WIDTH_LINE);
    localparam logic [COORD_W-1:0] BOT_START = COORD_W'(HEIGHT_SCREEN - WIDTH_LINE);
    localparam logic [COORD_W-1:0] BOT_END   = COORD_W'(HEIGHT_SCREEN);
    localparam logic [COORD_W-1:0] CTR_START = COORD_W'(WIDTH_SCREEN / 2 - WIDTH_LINE / 2);
    localparam logic [COORD_W-1:0] CTR_END   = COORD_W'(WIDTH_SCREEN / 2 + WIDTH_LINE / 2);
    localparam int                 DASH_BIT  = $clog2(DASH_LEN);

    logic [COORD_W-1:0] xc, yc;
    logic               active;
    logic               tick, inv, flashing;
    flash_state_e       flash_state;
    logic               unused_flash_state;

    mode_e              mode_q, mode_d;
    logic [RGB_W-1:0]   rgb_str_q, rgb_str_d;
    logic               flashing_q, flashing_d;

    logic               on_top, on_bottom, on_ctr, dash_on, court;
    logic [2:0]         colour;

    assign xc     = VGAStr_i[XC_MSB:XC_LSB];
    assign yc     = VGAStr_i[YC_MSB:YC_LSB];
    assign active = VGAStr_i[ACTIVE_BIT];

    pxs_frame_flash #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_PERIOD (FLASH_PERIOD),
        .VS_ACTIVE    (VS_ACTIVE)
    ) u_frame_flash (
        .px_clk     (px_clk),
        .reset_n    (reset_n),
        .vs_i       (VGAStr_i[VS_BIT]),
        .goal_i     (goal_i),
        .tick_o     (tick),
        .inv_o      (inv),
        .flashing_o (flashing),
        .state_o    (flash_state)
    );

    // FSM state is a debug observation point only; flashing carries the same information.
    assign unused_flash_state = ^flash_state;

    always_comb begin
        mode_d = mode_q;
        if (tick) begin
            mode_d = mode_e'(mode_i);
        end

        on_top    = (yc < TOP_END);
        on_bottom = (yc >= BOT_START) && (yc < BOT_END);
        on_ctr    = (xc >= CTR_START) && (xc < CTR_END);
        dash_on   = ~yc[DASH_BIT];

        court = 1'b0;
        case (mode_q)
            MODE_DASHED:   court = on_top | on_bottom | (on_ctr & dash_on);
            MODE_SOLID:    court = on_top | on_bottom | on_ctr;
            MODE_NOCENTRE: court = on_top | on_bottom;
            MODE_OFF:      court = 1'b0;
            default:       court = 1'b0;
        endcase

        // Inversion swaps court and background; blanking overrides everything.
        colour = (court ^ inv) ? COURT_COLOR : BG_COLOR;
        if (!active) begin
            colour = BLACK;
        end

        rgb_str_d  = {colour, VGAStr_i};
        flashing_d = flashing;
    end

    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= MODE_DASHED;
            rgb_str_q  <= '0;
            flashing_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            rgb_str_q  <= rgb_str_d;
            flashing_q <= flashing_d;
        end
    end

    assign RGBStr_o   = rgb_str_q;
    assign flashing_o = flashing_q;

endmodule

// File: tb/tb_pxs_court_gen.sv
// Bench for pxs_court_gen: directed steps plus randomized pixels, checked
// against an arithmetic model of the court rules (flash shortened to 8/2).
module tb_pxs_court_gen;

    logic        px_clk = 1'b0;
    logic        reset_n;
    logic [22:0] vga;
    logic [1:0]  mode;
    logic        goal;
    logic [25:0] rgb_str;
    logic        flashing;

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q[$];

    // Reference model state
    int m_vs_prev, m_mode, m_flash, m_frames;

    always #5 px_clk = ~px_clk;

    pxs_court_gen #(
        .FLASH_FRAMES (8),
        .FLASH_PERIOD (2)
    ) dut (
        .px_clk     (px_clk),
        .reset_n    (reset_n),
        .VGAStr_i   (vga),
        .mode_i     (mode),
        .goal_i     (goal),
        .RGBStr_o   (rgb_str),
        .flashing_o (flashing)
    );

    function automatic logic [22:0] pix(input int x, input int y, input bit act, input bit vs);
        logic [9:0] xv, yv;
        xv = 10'(x);
        yv = 10'(y);
        return {xv, yv, 1'b0, vs, act};
    endfunction

    function automatic logic [2:0] model_rgb(input logic [22:0] p);
        int  x, y;
        bit  top, bot, ctr, dash, court, inv;
        x = int'(p[22:13]);
        y = int'(p[12:3]);
        if (!p[0]) return 3'b000;
        top  = (y < 6);
        bot  = (y >= 474) && (y < 480);
        ctr  = (x >= 317) && (x < 323);
        dash = (y % 16) < 8;
        case (m_mode)
            0:       court = top || bot || (ctr && dash);
            1:       court = top || bot || ctr;
            2:       court = top || bot;
            default: court = 1'b0;
        endcase
        inv = (m_flash != 0) && (((m_frames / 2) % 2) == 0);
        return (court != inv) ? 3'b111 : 3'b000;
    endfunction

    task automatic model_reset();
        m_vs_prev = 1;
        m_mode    = 0;
        m_flash   = 0;
        m_frames  = 0;
        exp_q.delete();
    endtask

    task automatic model_clock(input logic [22:0] p, input logic [1:0] md, input logic g);
        bit tick;
        tick = (p[1] == 1'b0) && (m_vs_prev == 1);
        if (g) begin
            m_flash  = 1;
            m_frames = 0;
        end else if (m_flash != 0 && tick) begin
            m_frames++;
            if (m_frames == 8) begin
                m_flash  = 0;
                m_frames = 0;
            end
        end
        if (tick) m_mode = int'(md);
        m_vs_prev = int'(p[1]);
    endtask

    task automatic check(input string tag, input logic [25:0] obs, input logic [25:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [22:0] p, input logic [1:0] md, input logic g,
                        input string tag, input int want = -1);
        logic [26:0] e;
        @(negedge px_clk);
        vga  = p;
        mode = md;
        goal = g;
        exp_q.push_back({1'(m_flash), model_rgb(p), p});
        @(posedge px_clk);
        model_clock(p, md, g);
        #1;
        e = exp_q.pop_front();
        check({tag, "_rgbstr"}, rgb_str, e[25:0]);
        check({tag, "_flashing"}, {25'b0, flashing}, {25'b0, e[26]});
        if (want >= 0) check({tag, "_const"}, {23'b0, rgb_str[25:23]}, 26'(want));
    endtask

    task automatic vsync(input logic [1:0] md, input logic g);
        step(pix(0, 0, 0, 0), md, g, "vs_a");
        step(pix(0, 0, 0, 0), md, 1'b0, "vs_b");
        step(pix(0, 0, 0, 1), md, 1'b0, "vs_c");
    endtask

    task automatic rand_pixels(input int n, input logic [1:0] md, input int goal_odds);
        int x, y;
        bit act, g;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin x = $urandom_range(314, 325); y = $urandom_range(0, 479); end
                1: begin x = $urandom_range(0, 799);   y = $urandom_range(0, 8);   end
                2: begin x = $urandom_range(0, 799);   y = $urandom_range(470, 484); end
                default: begin x = $urandom_range(0, 799); y = $urandom_range(0, 524); end
            endcase
            act = ($urandom_range(0, 7) != 0);
            g   = (goal_odds > 0) && ($urandom_range(0, goal_odds) == 0);
            step(pix(x, y, act, 1), md, g, "rand");
        end
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        vga     = pix(0, 0, 0, 1);
        mode    = 2'b00;
        goal    = 1'b0;
        model_reset();
        repeat (3) @(posedge px_clk);
        #1;
        check("reset_rgbstr", rgb_str, 26'h0);
        check("reset_flashing", {25'b0, flashing}, 26'h0);
        @(negedge px_clk);
        reset_n = 1'b1;

        // Geometry in dashed mode
        step(pix(320, 20, 1, 1), 2'b00, 1'b0, "t1_320_20", 7);
        step(pix(320, 30, 1, 1), 2'b00, 1'b0, "t1_320_30", 0);
        step(pix(316, 20, 1, 1), 2'b00, 1'b0, "t1_316_20", 0);
        step(pix(317, 20, 1, 1), 2'b00, 1'b0, "t1_317_20", 7);
        step(pix(323, 20, 1, 1), 2'b00, 1'b0, "t1_323_20", 0);
        step(pix(100, 0, 1, 1),   2'b00, 1'b0, "t1_100_0", 7);
        step(pix(100, 5, 1, 1),   2'b00, 1'b0, "t1_100_5", 7);
        step(pix(100, 474, 1, 1), 2'b00, 1'b0, "t1_100_474", 7);
        step(pix(100, 479, 1, 1), 2'b00, 1'b0, "t1_100_479", 7);
        step(pix(100, 6, 1, 1),   2'b00, 1'b0, "t1_100_6", 0);
        step(pix(100, 473, 1, 1), 2'b00, 1'b0, "t1_100_473", 0);

        // Latency and blanking
        step(23'h5A5A5, 2'b00, 1'b0, "t2_lat");
        check("t2_copy", {3'b0, rgb_str[22:0]}, {3'b0, 23'h5A5A5});
        step(pix(100, 0, 0, 1), 2'b00, 1'b0, "t2_blank", 0);

        // Mode shadow
        step(pix(320, 30, 1, 1), 2'b01, 1'b0, "t3_pre", 0);
        rand_pixels(4, 2'b01, 0);
        step(pix(320, 30, 1, 1), 2'b01, 1'b0, "t3_still", 0);
        vsync(2'b01, 1'b0);
        step(pix(320, 30, 1, 1), 2'b01, 1'b0, "t3_post", 7);
        vsync(2'b11, 1'b0);
        step(pix(320, 20, 1, 1), 2'b11, 1'b0, "t3_off_ctr", 0);
        step(pix(100, 0, 1, 1),  2'b11, 1'b0, "t3_off_top", 0);
        rand_pixels(10, 2'b11, 0);

        // Goal flash over a full 8-frame run
        vsync(2'b00, 1'b0);
        step(pix(320, 20, 1, 1), 2'b00, 1'b1, "t4_goal", 7);
        step(pix(320, 20, 1, 1), 2'b00, 1'b0, "t4_inv", 0);
        check("t4_flash_on", {25'b0, flashing}, 26'h1);
        for (int f = 0; f < 9; f++) begin
            rand_pixels(6, 2'b00, 0);
            step(pix(320, 20, 1, 1),  2'b00, 1'b0, "t4_ctr");
            step(pix(200, 200, 1, 1), 2'b00, 1'b0, "t4_bg");
            vsync(2'b00, 1'b0);
        end
        step(pix(200, 200, 1, 1), 2'b00, 1'b0, "t4_idle", 0);
        check("t4_flash_off", {25'b0, flashing}, 26'h0);

        // Retrigger on a frame tick at frame_cnt = 5
        step(pix(100, 0, 1, 1), 2'b00, 1'b1, "t5_goal");
        for (int f = 0; f < 5; f++) begin
            rand_pixels(4, 2'b00, 0);
            vsync(2'b00, 1'b0);
        end
        step(pix(200, 200, 1, 1), 2'b00, 1'b0, "t5_cnt5", 7);
        vsync(2'b00, 1'b1);
        step(pix(200, 200, 1, 1), 2'b00, 1'b0, "t5_restart", 7);
        for (int f = 0; f < 9; f++) begin
            rand_pixels(5, 2'b00, 0);
            step(pix(100, 2, 1, 1), 2'b00, 1'b0, "t5_top");
            vsync(2'b00, 1'b0);
        end
        step(pix(100, 2, 1, 1), 2'b00, 1'b0, "t5_done", 7);

        // Randomized frames with random modes and occasional goals
        for (int f = 0; f < 12; f++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            rand_pixels(25, md, 30);
            vsync(md, 1'(($urandom_range(0, 5) == 0)));
        end

        // Asynchronous reset during a flash
        vsync(2'b00, 1'b0);
        step(pix(100, 0, 1, 1), 2'b00, 1'b1, "t6_goal");
        step(pix(100, 0, 1, 1), 2'b00, 1'b0, "t6_inv", 0);
        @(posedge px_clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_async_rgbstr", rgb_str, 26'h0);
        check("t6_async_flashing", {25'b0, flashing}, 26'h0);
        model_reset();
        repeat (2) @(posedge px_clk);
        #1;
        check("t6_held_rgbstr", rgb_str, 26'h0);
        @(negedge px_clk);
        reset_n = 1'b1;
        step(pix(320, 20, 1, 1),  2'b00, 1'b0, "t6_ctr", 7);
        step(pix(320, 30, 1, 1),  2'b00, 1'b0, "t6_gap", 0);
        step(pix(100, 0, 1, 1),   2'b00, 1'b0, "t6_top", 7);
        step(pix(200, 200, 1, 1), 2'b00, 1'b0, "t6_bg", 0);
        check("t6_noflash", {25'b0, flashing}, 26'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
